// File: rtl/tmds_pkg.sv
// Shared TMDS constants and types: control tokens, symbol width and decoder FSM states.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;

  // Control tokens as transmitted, bit 9 down to bit 0
  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: recognises control tokens and undoes the
// transition-minimising and DC-balancing steps for data symbols.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output logic             is_token,
  output logic             c1,
  output logic             c0,
  output logic [7:0]       data
);

  logic [7:0] d;

  always_comb begin
    is_token = 1'b1;
    c1       = 1'b0;
    c0       = 1'b0;
    case (sym)
      CTRL_00: {c1, c0} = 2'b00;
      CTRL_01: {c1, c0} = 2'b01;
      CTRL_10: {c1, c0} = 2'b10;
      CTRL_11: {c1, c0} = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  // Bit 9 flags inversion; bit 8 selects XOR (1) versus XNOR (0) chaining
  always_comb begin
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// Single-lane TMDS receive decoder: word alignment by control-token hunting, then
// symbol decode. Define TMDS_ERR_CNT_EN to add the err_cnt lock-loss counter port.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS = 16,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic [SYM_W-1:0] tmds_raw,
  output logic [7:0]       data,
  output logic             c0,
  output logic             c1,
  output logic             de,
  output logic             locked,
  output logic [3:0]       align_offset
`ifdef TMDS_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_TOKENS);
  localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT);

  logic [SYM_W-1:0]   prev_q, sym_q, sym_d;
  logic [2*SYM_W-2:0] win;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   run_q, run_d, tmo_q, tmo_d, tmo_inc;
  logic [3:0]         off_q, off_d, off_inc;
  logic [7:0]         data_q;
  logic               c0_q, c1_q, de_q;

  logic               is_token, tok_c0, tok_c1;
  logic [7:0]         dec_data;

  // Top bit of tmds_raw can never land inside a 10-bit window at offsets 0..9
  assign win = {tmds_raw[SYM_W-2:0], prev_q};

  always_comb begin
    sym_d = prev_q;
    for (int k = 1; k < SYM_W; k++) begin
      if (off_q == 4'(k)) sym_d = win[k +: SYM_W];
    end
  end

  tmds_symbol_decode u_dec (
    .sym      (sym_q),
    .is_token (is_token),
    .c1       (tok_c1),
    .c0       (tok_c0),
    .data     (dec_data)
  );

  assign tmo_inc = tmo_q + 1'b1;
  assign off_inc = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    off_d   = off_q;
    tmo_d   = is_token ? '0 : tmo_inc;
    unique case (state_q)
      SEARCH: begin
        run_d = is_token ? run_q + 1'b1 : '0;
        if (is_token && (run_q + 1'b1) == LOCK_CNT) begin
          state_d = LOCKED;
          run_d   = '0;
        end else if (!is_token && tmo_inc == TMO_CNT) begin
          off_d = off_inc;
          run_d = '0;
          tmo_d = '0;
        end
      end
      LOCKED: begin
        if (!is_token && tmo_inc == TMO_CNT) begin
          state_d = SEARCH;
          off_d   = off_inc;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      prev_q  <= '0;
      sym_q   <= '0;
      state_q <= SEARCH;
      run_q   <= '0;
      tmo_q   <= '0;
      off_q   <= '0;
      data_q  <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      prev_q  <= tmds_raw;
      sym_q   <= sym_d;
      state_q <= state_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
      off_q   <= off_d;
      if (is_token) begin
        c0_q   <= tok_c0;
        c1_q   <= tok_c1;
        de_q   <= 1'b0;
        data_q <= '0;
      end else begin
        de_q   <= 1'b1;
        data_q <= dec_data;
      end
    end
  end

  // Gating also hides the stale pipeline contents left behind after lock loss
  assign locked       = (state_q == LOCKED);
  assign data         = locked ? data_q : '0;
  assign c0           = locked & c0_q;
  assign c1           = locked & c1_q;
  assign de           = locked & de_q;
  assign align_offset = off_q;

`ifdef TMDS_ERR_CNT_EN
  logic [15:0] err_q;
  logic        lock_lost;

  assign lock_lost = (state_q == LOCKED) && (state_d == SEARCH);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      err_q <= '0;
    end else if (lock_lost && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: a bit-serial transmitter model with an adjustable
// skew feeds the DUT; a behavioural receiver model predicts every output cycle.
`timescale 1ns/1ps
module tb_tmds_decoder;

  localparam int LOCK_TOKENS = 16;
  localparam int TIMEOUT     = 64;
  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] tmds_raw;
  logic [7:0] data;
  logic       c0, c1, de, locked;
  logic [3:0] align_offset;
  logic [15:0] err_obs;

`ifdef TMDS_ERR_CNT_EN
  logic [15:0] err_cnt;
  assign err_obs = err_cnt;
`else
  assign err_obs = 16'd0;
`endif

  tmds_decoder #(
    .LOCK_TOKENS (LOCK_TOKENS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .tmds_raw     (tmds_raw),
    .data         (data),
    .c0           (c0),
    .c1           (c1),
    .de           (de),
    .locked       (locked),
    .align_offset (align_offset)
`ifdef TMDS_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [7:0]  data;
    logic        c1;
    logic        c0;
    logic        de;
    logic        locked;
    logic [3:0]  off;
    logic [15:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Receiver reference model state
  logic [9:0] m_prev, m_sym;
  logic [3:0] m_off;
  bit         m_locked;
  int         m_run, m_tmo, m_err;
  logic [7:0] m_data;
  logic       m_c0, m_c1, m_de;

  // Transmitter: serial symbol stream delayed by k bits before 1:10 deserialisation
  logic [9:0] tx_prev = 10'd0, tx_cur = 10'd0;
  int         k = 0;

  task automatic model_step(input logic rst_v, input logic [9:0] raw);
    int         tok;
    logic [3:0] new_off;
    logic [19:0] w;
    logic [7:0]  dd;
    if (rst_v) begin
      m_prev = '0; m_sym = '0; m_off = '0; m_locked = 0; m_run = 0; m_tmo = 0;
      m_err = 0; m_data = '0; m_c0 = 0; m_c1 = 0; m_de = 0;
      return;
    end
    tok = -1;
    for (int i = 0; i < 4; i++) if (m_sym == TOK[i]) tok = i;
    if (tok >= 0) begin
      m_c1 = tok[1]; m_c0 = tok[0]; m_de = 0; m_data = '0;
    end else begin
      dd = m_sym[9] ? ~m_sym[7:0] : m_sym[7:0];
      m_data[0] = dd[0];
      for (int i = 1; i < 8; i++) m_data[i] = (dd[i] ^ dd[i-1]) ^ ~m_sym[8];
      m_de = 1;
    end
    new_off = m_off;
    if (tok >= 0) begin
      m_tmo = 0;
      if (!m_locked) begin
        m_run++;
        if (m_run == LOCK_TOKENS) begin m_locked = 1; m_run = 0; end
      end
    end else begin
      m_run = 0;
      m_tmo++;
      if (m_tmo == TIMEOUT) begin
        new_off = (m_off == 4'd9) ? 4'd0 : m_off + 4'd1;
        m_tmo = 0;
        if (m_locked) begin
          m_locked = 0;
          if (m_err < 65535) m_err++;
        end
      end
    end
    w = {raw, m_prev} >> m_off;
    m_sym  = w[9:0];
    m_prev = raw;
    m_off  = new_off;
  endtask

  task automatic push_expected();
    exp_t e;
    e.locked = m_locked;
    e.data   = m_locked ? m_data : 8'd0;
    e.c1     = m_locked & m_c1;
    e.c0     = m_locked & m_c0;
    e.de     = m_locked & m_de;
    e.off    = m_off;
`ifdef TMDS_ERR_CNT_EN
    e.err    = 16'(m_err);
`else
    e.err    = 16'd0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [9:0] s, input logic rst_v);
    logic [19:0] pair;
    tx_prev  = tx_cur;
    tx_cur   = s;
    pair     = {tx_cur, tx_prev} >> (10 - k);
    tmds_raw = pair[9:0];
    reset    = rst_v;
    @(posedge clk_pixel);
    model_step(rst_v, tmds_raw);
    push_expected();
    #1;
  endtask

  function automatic logic [9:0] rand_sym();
    return 10'($urandom);
  endfunction

  // Monitor: every cycle presents an output word
  always @(negedge clk_pixel) begin
    exp_t e, o;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '{data: data, c1: c1, c0: c0, de: de, locked: locked, off: align_offset, err: err_obs};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got data=%h c1c0=%b%b de=%b locked=%b off=%0d err=%0d, want data=%h c1c0=%b%b de=%b locked=%b off=%0d err=%0d",
                 $time, o.data, o.c1, o.c0, o.de, o.locked, o.off, o.err,
                 e.data, e.c1, e.c0, e.de, e.locked, e.off, e.err);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tmds_raw = '0;
    repeat (3) send(10'd0, 1'b1);

    // Aligned lock, then fixed data and token symbols
    k = 0;
    repeat (40) send(TOK[0], 1'b0);
    send(10'h100, 1'b0); send(10'h3FF, 1'b0); send(10'h0FF, 1'b0);
    send(TOK[1], 1'b0); send(TOK[2], 1'b0); send(TOK[3], 1'b0);
    send(10'h155, 1'b0); send(10'h2C3, 1'b0); send(TOK[0], 1'b0);

    // Locked random traffic with frequent tokens
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) send(TOK[$urandom_range(0, 3)], 1'b0);
      else send(rand_sym(), 1'b0);
    end
    repeat (5) send(TOK[0], 1'b0);

    // Lock loss through a long data-only run
    repeat (70) send(10'h100 | 10'($urandom_range(0, 255)), 1'b0);

    // Skewed stream: decoder must slip up to offset 7
    k = 7;
    repeat (8 * TIMEOUT + 40) send(TOK[0], 1'b0);
    repeat (20) send(rand_sym(), 1'b0);
    send(TOK[3], 1'b0);

    // Relock at offset 5 from reset, then reset while locked
    k = 5;
    send(TOK[0], 1'b1);
    repeat (6 * TIMEOUT + 40) send(TOK[0], 1'b0);
    send(TOK[2], 1'b1);
    repeat (10) send(TOK[0], 1'b0);

    // Random skew and mixed traffic
    for (int r = 0; r < 2; r++) begin
      k = $urandom_range(0, 9);
      send(TOK[0], 1'b1);
      repeat (10 * TIMEOUT + 40) send(TOK[$urandom_range(0, 3)] & 10'h3FF | 10'(0), 1'b0);
      repeat (400) begin
        if ($urandom_range(0, 4) == 0) send(TOK[$urandom_range(0, 3)], 1'b0);
        else send(rand_sym(), 1'b0);
      end
    end

    reset = 1'b0;
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    if (exp_q.size() != 0 || n_cmp < 12) begin
      n_bad++;
      $display("FAIL drain: got %0d compared with %0d pending, want >=12 compared and 0 pending",
               n_cmp, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
